// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a single-port 256x8 register file between NUM_REQ requesters,
// with a bounded grant lock and a one-cycle-latency response channel.
module regfile_arbiter #(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ-1:0]   req_we,
   input  logic [NUM_REQ-1:0]   req_lock,
   input  logic [8*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [7:0]           rsp_data,
   output logic                 rf_we,
   output logic [7:0]           rf_addr,
   output logic [7:0]           rf_data_in,
   input  logic [7:0]           rf_data_out
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [IW-1:0] idx_t;
   typedef enum logic {ST_OPEN, ST_LOCKED} lock_st_e;

   function automatic idx_t inc_idx(input idx_t i);
      return (32'(i) == NUM_REQ - 1) ? '0 : i + idx_t'(1);
   endfunction

   lock_st_e   lock_st_q, lock_st_d;
   idx_t       rr_ptr_q, rr_ptr_d;
   idx_t       lock_owner_q, lock_owner_d;
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic       relock_blk_q, relock_blk_d;
   idx_t       blk_owner_q, blk_owner_d;
   logic       rsp_vld_q;
   idx_t       rsp_own_q;

   logic       hs;
   idx_t       gnt;
   idx_t       start;
   logic [IW:0] cand;
   logic       want;
   logic [8:0] base;

   // A locked owner that stays valid is the only candidate; once it drops, the search
   // starts just past it so another requester can be served in that same cycle.
   always_comb begin
      hs    = 1'b0;
      gnt   = '0;
      cand  = '0;
      start = (lock_st_q == ST_LOCKED) ? inc_idx(lock_owner_q) : rr_ptr_q;
      if (lock_st_q == ST_LOCKED && req_valid[lock_owner_q]) begin
         hs  = 1'b1;
         gnt = lock_owner_q;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, start} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!hs && req_valid[cand[IW-1:0]]) begin
               hs  = 1'b1;
               gnt = cand[IW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready  = hs ? (NUM_REQ'(1) << gnt) : '0;
      rf_we      = hs & req_we[gnt] & rst_n;
      rf_addr    = hs ? req_addr[{gnt, 3'b000} +: 8] : '0;
      rf_data_in = hs ? req_wdata[{gnt, 3'b000} +: 8] : '0;
      rsp_valid  = rsp_vld_q ? (NUM_REQ'(1) << rsp_own_q) : '0;
      rsp_data   = rsp_vld_q ? rf_data_out : '0;
   end

   always_comb begin
      lock_st_d    = lock_st_q;
      rr_ptr_d     = rr_ptr_q;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = lock_cnt_q;
      relock_blk_d = relock_blk_q;
      blk_owner_d  = blk_owner_q;
      want         = 1'b0;
      base         = '0;
      if (lock_st_q == ST_LOCKED && !req_valid[lock_owner_q]) begin
         lock_st_d  = ST_OPEN;
         lock_cnt_d = '0;
         rr_ptr_d   = inc_idx(lock_owner_q);
      end
      if (hs) begin
         if (relock_blk_q && gnt != blk_owner_q) relock_blk_d = 1'b0;
         want = req_lock[gnt] && !(relock_blk_q && gnt == blk_owner_q);
         base = (lock_st_q == ST_LOCKED && gnt == lock_owner_q) ? {1'b0, lock_cnt_q} : '0;
         if (want && (base + 9'd1) < 9'(LOCK_MAX)) begin
            lock_st_d    = ST_LOCKED;
            lock_owner_d = gnt;
            lock_cnt_d   = 8'(base + 9'd1);
         end else begin
            lock_st_d  = ST_OPEN;
            lock_cnt_d = '0;
            rr_ptr_d   = inc_idx(gnt);
            // Forced release: bar this owner from relocking until someone else is served.
            if (want) begin
               relock_blk_d = 1'b1;
               blk_owner_d  = gnt;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_st_q    <= ST_OPEN;
         rr_ptr_q     <= '0;
         lock_owner_q <= '0;
         lock_cnt_q   <= '0;
         relock_blk_q <= 1'b0;
         blk_owner_q  <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_own_q    <= '0;
      end else begin
         lock_st_q    <= lock_st_d;
         rr_ptr_q     <= rr_ptr_d;
         lock_owner_q <= lock_owner_d;
         lock_cnt_q   <= lock_cnt_d;
         relock_blk_q <= relock_blk_d;
         blk_owner_q  <= blk_owner_d;
         rsp_vld_q    <= hs;
         rsp_own_q    <= gnt;
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model and a read-first register file.
module tb_regfile_arbiter;

   localparam int N    = 2;
   localparam int LMAX = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0, req_we = '0, req_lock = '0;
   logic [N-1:0]   req_ready, rsp_valid;
   logic [8*N-1:0] req_addr = '0, req_wdata = '0;
   logic [7:0]     rsp_data, rf_addr, rf_data_in;
   logic           rf_we;
   logic [7:0]     rf_data_out;

   logic [7:0]     mem [256];
   logic           init_done = 1'b0;

   int n_pass = 0, n_total = 0;

   // reference model state
   int         ref_mem [256];
   int         m_ptr, m_owner, m_cnt, m_blk_own, m_rsp_own, m_rsp_data, e_gnt;
   bit         m_locked, m_blk, m_pend;
   logic [N-1:0] exp_ready, exp_rsp_v;
   logic         exp_we;
   logic [7:0]   exp_addr, exp_wd, exp_rsp_d;

   regfile_arbiter #(.NUM_REQ(N), .LOCK_MAX(LMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      return 8'(a ^ 32'h3C);
   endfunction

   // single-port register file with registered, read-first output
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         init_done   <= 1'b1;
         rf_data_out <= '0;
      end else begin
         rf_data_out <= mem[rf_addr];
         if (rf_we) mem[rf_addr] <= rf_data_in;
      end
   end

   task automatic model_reset;
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
      m_blk = 0; m_blk_own = 0; m_pend = 0; m_rsp_own = 0; m_rsp_data = 0;
   endtask

   task automatic model_eval;
      int start, c;
      e_gnt = -1;
      if (m_locked && req_valid[m_owner]) e_gnt = m_owner;
      else begin
         start = m_locked ? (m_owner + 1) % N : m_ptr;
         for (int i = 0; i < N; i++) begin
            c = (start + i) % N;
            if (e_gnt < 0 && req_valid[c]) e_gnt = c;
         end
      end
      exp_ready = '0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
      if (e_gnt >= 0) begin
         exp_ready[e_gnt] = 1'b1;
         exp_we   = req_we[e_gnt];
         exp_addr = req_addr[8*e_gnt +: 8];
         exp_wd   = req_wdata[8*e_gnt +: 8];
      end
      exp_rsp_v = '0;
      if (m_pend) exp_rsp_v[m_rsp_own] = 1'b1;
      exp_rsp_d = m_pend ? 8'(m_rsp_data) : 8'h00;
   endtask

   task automatic model_commit;
      bit want;
      int b;
      if (m_locked && !req_valid[m_owner]) begin
         m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
      end
      m_pend = (e_gnt >= 0);
      if (e_gnt >= 0) begin
         m_rsp_own  = e_gnt;
         m_rsp_data = ref_mem[int'(req_addr[8*e_gnt +: 8])];
         if (req_we[e_gnt]) ref_mem[int'(req_addr[8*e_gnt +: 8])] = int'(req_wdata[8*e_gnt +: 8]);
         if (m_blk && e_gnt != m_blk_own) m_blk = 0;
         want = req_lock[e_gnt] && !(m_blk && m_blk_own == e_gnt);
         b = (m_locked && m_owner == e_gnt) ? m_cnt : 0;
         if (want && b + 1 < LMAX) begin
            m_locked = 1; m_owner = e_gnt; m_cnt = b + 1;
         end else begin
            m_locked = 0; m_cnt = 0; m_ptr = (e_gnt + 1) % N;
            if (want) begin m_blk = 1; m_blk_own = e_gnt; end
         end
      end
   endtask

   task automatic apply(input logic [N-1:0] iv, iwe, ilk, input logic [7:0] a0, a1, d0, d1);
      @(negedge clk);
      req_valid = iv; req_we = iwe; req_lock = ilk;
      req_addr = {a1, a0}; req_wdata = {d1, d0};
      #1;
      model_eval;
   endtask

   task automatic advance;
      @(posedge clk);
      if (rst_n) model_commit;
   endtask

   task automatic do_reset;
      @(negedge clk);
      req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 2'b01; req_we = 2'b01; req_lock = '0;
      req_addr = {8'h00, 8'h30}; req_wdata = {8'h00, 8'hEE};
      #1;
      n_total++;
      if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b exp=0", rf_we); else n_pass++;
      n_total++;
      if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); else n_pass++;
      n_total++;
      if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0; req_we = '0;
      rst_n = 1'b1;
      model_reset;
      apply(2'b11, 2'b00, 2'b00, 8'h30, 8'h31, 8'h00, 8'h00);
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL reset_first_grant got=%b exp=01", req_ready); else n_pass++;
      advance;
      apply(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      n_total++;
      if (rsp_valid !== 2'b01 || rsp_data !== init_val(8'h30))
         $display("FAIL reset_no_write got=%b/%h exp=01/%h", rsp_valid, rsp_data, init_val(8'h30));
      else n_pass++;
      advance;
   endtask

   task automatic test_write_read;
      do_reset;
      apply(2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 8'h5A, 8'h00);
      n_total++;
      if (req_ready !== 2'b01 || rf_we !== 1'b1 || rf_addr !== 8'h10 || rf_data_in !== 8'h5A)
         $display("FAIL wr_issue got=%b/%b/%h/%h exp=01/1/10/5a", req_ready, rf_we, rf_addr, rf_data_in);
      else n_pass++;
      advance;
      apply(2'b10, 2'b00, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00);
      n_total++;
      if (req_ready !== 2'b10 || rf_we !== 1'b0 || rf_addr !== 8'h10)
         $display("FAIL rd_issue got=%b/%b/%h exp=10/0/10", req_ready, rf_we, rf_addr);
      else n_pass++;
      n_total++;
      if (rsp_valid !== 2'b01) $display("FAIL wr_ack got=%b exp=01", rsp_valid); else n_pass++;
      advance;
      apply(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      n_total++;
      if (rsp_valid !== 2'b10 || rsp_data !== 8'h5A)
         $display("FAIL rd_rsp got=%b/%h exp=10/5a", rsp_valid, rsp_data);
      else n_pass++;
      n_total++;
      if (req_ready !== 2'b00 || rf_addr !== 8'h00) $display("FAIL idle_bus got=%b/%h exp=00/00", req_ready, rf_addr); else n_pass++;
      advance;
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] e, prev;
      logic [7:0]   prev_d;
      do_reset;
      prev = 2'b00; prev_d = 8'h00;
      for (int c = 0; c < 7; c++) begin
         if (c < 6) apply(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
         else       apply(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
         e = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
         n_total++;
         if (req_ready !== e) $display("FAIL rot_grant cyc=%0d got=%b exp=%b", c, req_ready, e); else n_pass++;
         n_total++;
         if (rsp_valid !== prev || rsp_data !== prev_d)
            $display("FAIL rot_rsp cyc=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_data, prev, prev_d);
         else n_pass++;
         prev   = e;
         prev_d = (e == 2'b01) ? init_val(1) : ((e == 2'b10) ? init_val(2) : 8'h00);
         advance;
      end
   endtask

   task automatic test_swap;
      do_reset;
      apply(2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h11);
      advance;
      apply(2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h22);
      n_total++;
      if (rf_we !== 1'b1 || rf_data_in !== 8'h22) $display("FAIL swap_issue got=%b/%h exp=1/22", rf_we, rf_data_in); else n_pass++;
      advance;
      apply(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00);
      n_total++;
      if (rsp_valid !== 2'b10 || rsp_data !== 8'h11)
         $display("FAIL swap_old got=%b/%h exp=10/11", rsp_valid, rsp_data);
      else n_pass++;
      advance;
      apply(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      n_total++;
      if (rsp_valid !== 2'b10 || rsp_data !== 8'h22)
         $display("FAIL swap_new got=%b/%h exp=10/22", rsp_valid, rsp_data);
      else n_pass++;
      advance;
   endtask

   task automatic test_lock_forced;
      logic [N-1:0] e;
      do_reset;
      for (int c = 0; c <= LMAX; c++) begin
         apply(2'b11, 2'b00, 2'b01, 8'h05, 8'h06, 8'h00, 8'h00);
         e = (c < LMAX) ? 2'b01 : 2'b10;
         n_total++;
         if (req_ready !== e) $display("FAIL lock_grant cyc=%0d got=%b exp=%b", c, req_ready, e); else n_pass++;
         advance;
      end
      apply(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      advance;
   endtask

   task automatic test_lock_drop;
      logic [N-1:0] e [4];
      e[0] = 2'b01; e[1] = 2'b10; e[2] = 2'b01; e[3] = 2'b10;
      do_reset;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: apply(2'b11, 2'b00, 2'b01, 8'h07, 8'h08, 8'h00, 8'h00);
            1: apply(2'b10, 2'b00, 2'b01, 8'h07, 8'h08, 8'h00, 8'h00);
            default: apply(2'b11, 2'b00, 2'b00, 8'h07, 8'h08, 8'h00, 8'h00);
         endcase
         n_total++;
         if (req_ready !== e[c]) $display("FAIL lock_drop cyc=%0d got=%b exp=%b", c, req_ready, e[c]); else n_pass++;
         advance;
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      apply(2'b11, 2'b00, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00);
      advance;
      @(negedge clk);
      req_valid = 2'b11; req_we = 2'b01; req_lock = 2'b00;
      req_addr = {8'h41, 8'h40}; req_wdata = {8'h00, 8'h99};
      #1;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (rf_we !== 1'b0) $display("FAIL mid_rf_we got=%b exp=0", rf_we); else n_pass++;
      n_total++;
      if (rsp_valid !== 2'b00) $display("FAIL mid_rsp_drop got=%b exp=00", rsp_valid); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0; req_we = '0;
      rst_n = 1'b1;
      model_reset;
      apply(2'b11, 2'b00, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00);
      n_total++;
      if (rsp_valid !== 2'b00) $display("FAIL mid_rsp_after got=%b exp=00", rsp_valid); else n_pass++;
      n_total++;
      if (req_ready !== 2'b01) $display("FAIL mid_grant got=%b exp=01", req_ready); else n_pass++;
      advance;
      apply(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      n_total++;
      if (rsp_data !== init_val(8'h40)) $display("FAIL mid_no_write got=%h exp=%h", rsp_data, init_val(8'h40)); else n_pass++;
      advance;
   endtask

   task automatic test_random;
      logic [N-1:0] v, w, l;
      do_reset;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            v[i] = ($urandom_range(0, 9) < 7);
            w[i] = ($urandom_range(0, 9) < 3);
            l[i] = ($urandom_range(0, 9) < 4);
         end
         apply(v, w, l, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
         n_total++;
         if (req_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready); else n_pass++;
         n_total++;
         if (rf_we !== exp_we) $display("FAIL rnd_rf_we cyc=%0d got=%b exp=%b", c, rf_we, exp_we); else n_pass++;
         n_total++;
         if (rf_addr !== exp_addr) $display("FAIL rnd_rf_addr cyc=%0d got=%h exp=%h", c, rf_addr, exp_addr); else n_pass++;
         n_total++;
         if (rf_data_in !== exp_wd) $display("FAIL rnd_rf_data_in cyc=%0d got=%h exp=%h", c, rf_data_in, exp_wd); else n_pass++;
         n_total++;
         if (rsp_valid !== exp_rsp_v) $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_rsp_v); else n_pass++;
         n_total++;
         if (rsp_data !== exp_rsp_d) $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", c, rsp_data, exp_rsp_d); else n_pass++;
         advance;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = int'(init_val(i));
      model_reset;
      repeat (2) @(negedge clk);
      test_reset;
      test_write_read;
      test_back_to_back;
      test_swap;
      test_lock_forced;
      test_lock_drop;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
